dmem_arbiter: RTL and testbench

Two-port arbiter that shares the single-port 16-bit data memory between the pipeline MEM stage (port 0) and the debug/loader port (port 1). Per cycle it grants at most one requester, drives the memory's address/write-data/write-enable, and returns registered read data with a valid pulse one cycle later. It sits between the MEM stage (and the external loader) and the data memory instance. It also supplies the pipeline stall signal when port 0 is blocked.

---
 rtl/dmem_arbiter.sv | 146 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single-port 16-bit data memory between the pipeline MEM stage
//   (port 0) and the debug/loader port (port 1). At most one grant per cycle,
//   combinational grant, registered response one cycle after the grant.
//
//   Build option: define DMEM_ARB_RR_EN for round-robin on unlocked contention;
//   otherwise port 0 has fixed priority. Lock / forced release is the same in
//   both builds.
//
//   Parameters: N (memory depth in words), MAX_LOCK (max consecutive locked
//   port-1 grants while port 0 waits, 1..255).
//   Ports:
//     clk, rst                    clock, async active-low reset
//     reqX/weX/addrX/wdataX       request, held stable until granted
//     lock1                       port 1 burst lock request
//     gntX                        combinational grant
//     rvalidX/rdataX/errX         registered response (cycle after grant)
//     stall0                      port 0 requesting but not granted
//     mem_addr/mem_wdata/mem_we   memory drive
//     mem_rdata                   memory asynchronous read data
module dmem_arbiter #(
    parameter int N        = 16,
    parameter int MAX_LOCK = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [15:0] addr0,
    input  logic [15:0] addr1,
    input  logic [15:0] wdata0,
    input  logic [15:0] wdata1,
    input  logic        lock1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [15:0] rdata0,
    output logic [15:0] rdata1,
    output logic        err0,
    output logic        err1,
    output logic        stall0,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    input  logic [15:0] mem_rdata
);

    localparam logic [7:0]  LMAX  = 8'(MAX_LOCK);
    localparam logic [16:0] DEPTH = 17'(N);

    logic       last;       // port granted most recently
    logic       lock_hold;
    logic [7:0] lcnt;
    logic       inr0, inr1;
    logic       w0, w1;

    // 17-bit compare so N = 65536 still works
    assign inr0 = {1'b0, addr0} < DEPTH;
    assign inr1 = {1'b0, addr1} < DEPTH;

`ifndef DMEM_ARB_RR_EN
    // Pointer is maintained in the fixed build too so both builds carry the
    // same state; nothing reads it here.
    logic last_unused;
    assign last_unused = last;
`endif

    always_comb begin
        w0 = 1'b0;
        w1 = 1'b0;
        if (req0 && req1) begin
            if (lock_hold && (lcnt < LMAX)) begin
                w1 = 1'b1;
            end else if (lock_hold) begin
                w0 = 1'b1;  // forced release after MAX_LOCK locked grants
            end else begin
`ifdef DMEM_ARB_RR_EN
                if (last) w0 = 1'b1;
                else      w1 = 1'b1;
`else
                w0 = 1'b1;
`endif
            end
        end else if (req0) begin
            w0 = 1'b1;
        end else if (req1) begin
            // release only yields to a real requester, so a lone port 1 wins
            w1 = 1'b1;
        end
    end

    assign gnt0   = w0;
    assign gnt1   = w1;
    assign stall0 = req0 & ~w0;

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (w0) begin
            mem_addr  = addr0;
            mem_wdata = wdata0;
            mem_we    = we0 & inr0;
        end else if (w1) begin
            mem_addr  = addr1;
            mem_wdata = wdata1;
            mem_we    = we1 & inr1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
            err0      <= 1'b0;
            err1      <= 1'b0;
            last      <= 1'b1;  // port 0 goes first under round-robin
            lock_hold <= 1'b0;
            lcnt      <= '0;
        end else begin
            rvalid0 <= w0;
            rvalid1 <= w1;
            rdata0  <= (w0 && !we0 && inr0) ? mem_rdata : '0;
            rdata1  <= (w1 && !we1 && inr1) ? mem_rdata : '0;
            err0    <= w0 && !inr0;
            err1    <= w1 && !inr1;

            if (w0)      last <= 1'b0;
            else if (w1) last <= 1'b1;

            if (w0 || !lock1 || !req1) begin
                lock_hold <= 1'b0;
                lcnt      <= '0;
            end else if (w1) begin
                lock_hold <= 1'b1;
                if (lcnt < LMAX) lcnt <= lcnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic        clk, rst;
    logic        req0, req1, we0, we1, lock1;
    logic [15:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1, stall0, mem_we;
    logic [15:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

    logic        mem_init;
    logic [15:0] mem [0:63];

    int pass_cnt = 0;
    int total    = 0;

    dmem_arbiter #(.N(16), .MAX_LOCK(3)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .lock1(lock1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
        .stall0(stall0), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory: async read, write at the clock edge. Sized past N
    // so an out-of-range address never aliases an in-range word.
    assign mem_rdata = mem[mem_addr[5:0]];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 16'hA000 + 16'(i);
            mem[3] <= 16'h1000;
        end else if (mem_we) begin
            mem[mem_addr[5:0]] <= mem_wdata;
        end
    end

    typedef struct {
        logic r0, w0; logic [15:0] a0, d0;
        logic r1, w1; logic [15:0] a1, d1;
        logic l1;
        logic g0, g1, st, mwe; logic [15:0] maddr;
        logic rv0, rv1; logic [15:0] rd0, rd1; logic e0, e1;
    } vec_t;

    vec_t tv [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [15:0] a0, input logic [15:0] d0,
                         input logic r1, input logic w1, input logic [15:0] a1, input logic [15:0] d1,
                         input logic l1);
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
        lock1 = l1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(L, L, 16'd0, 16'd0, L, L, 16'd0, 16'd0, L);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        //            r0 w0 a0       d0        r1 w1 a1      d1        l1  g0 g1 st mwe maddr     rv0 rv1 rd0       rd1       e0 e1
        tv[0]  = '{H, L, 16'd3,  16'h0,    L, L, 16'd0,  16'h0,    L,  H, L, L, L, 16'd3,    H, L, 16'h1000, 16'h0,    L, L};
        tv[1]  = '{L, L, 16'd0,  16'h0,    L, L, 16'd0,  16'h0,    L,  L, L, L, L, 16'd0,    L, L, 16'h0,    16'h0,    L, L};
        tv[2]  = '{L, L, 16'd0,  16'h0,    H, H, 16'd5,  16'hBEEF, L,  L, H, L, H, 16'd5,    L, H, 16'h0,    16'h0,    L, L};
        tv[3]  = '{H, L, 16'd5,  16'h0,    L, L, 16'd0,  16'h0,    L,  H, L, L, L, 16'd5,    H, L, 16'hBEEF, 16'h0,    L, L};
        tv[4]  = '{H, H, 16'd16, 16'h1234, L, L, 16'd0,  16'h0,    L,  H, L, L, L, 16'd16,   H, L, 16'h0,    16'h0,    H, L};
        tv[5]  = '{L, L, 16'd0,  16'h0,    H, L, 16'd0,  16'h0,    L,  L, H, L, L, 16'd0,    L, H, 16'h0,    16'hA000, L, L};
        tv[6]  = '{L, L, 16'd0,  16'h0,    H, L, 16'd15, 16'h0,    L,  L, H, L, L, 16'd15,   L, H, 16'h0,    16'hA00F, L, L};
        tv[7]  = '{L, L, 16'd0,  16'h0,    H, L, 16'd16, 16'h0,    L,  L, H, L, L, 16'd16,   L, H, 16'h0,    16'h0,    L, H};
        tv[8]  = '{H, L, 16'hFFFF,16'h0,   L, L, 16'd0,  16'h0,    L,  H, L, L, L, 16'hFFFF, H, L, 16'h0,    16'h0,    H, L};
        tv[9]  = '{L, L, 16'd0,  16'h0,    H, H, 16'd15, 16'h5555, L,  L, H, L, H, 16'd15,   L, H, 16'h0,    16'h0,    L, L};
        tv[10] = '{H, L, 16'd15, 16'h0,    L, L, 16'd0,  16'h0,    L,  H, L, L, L, 16'd15,   H, L, 16'h5555, 16'h0,    L, L};
        tv[11] = '{H, H, 16'd0,  16'h7777, L, L, 16'd0,  16'h0,    H,  H, L, L, H, 16'd0,    H, L, 16'h0,    16'h0,    L, L};
        tv[12] = '{L, L, 16'd0,  16'h0,    H, L, 16'd0,  16'h0,    L,  L, H, L, L, 16'd0,    L, H, 16'h0,    16'h7777, L, L};

        rst = 1'b0;
        mem_init = 1'b1;
        drive(L, L, 16'd0, 16'd0, L, L, 16'd0, 16'd0, L);
        @(negedge clk);
        @(negedge clk);
        mem_init = 1'b0;
        chk("rst_rvalid0", rvalid0, 0);
        chk("rst_rvalid1", rvalid1, 0);
        chk("rst_rdata0", rdata0, 0);
        chk("rst_rdata1", rdata1, 0);
        chk("rst_err0", err0, 0);
        chk("rst_err1", err1, 0);
        chk("rst_gnt", {gnt0, gnt1, stall0, mem_we}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_last", dut.last, 1);
        chk("rst_lcnt", dut.lcnt, 0);
        chk("rst_lock_hold", dut.lock_hold, 0);
        rst = 1'b1;

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            drive(tv[i].r0, tv[i].w0, tv[i].a0, tv[i].d0,
                  tv[i].r1, tv[i].w1, tv[i].a1, tv[i].d1, tv[i].l1);
            #1;
            chk($sformatf("v%0d_gnt0", i), gnt0, tv[i].g0);
            chk($sformatf("v%0d_gnt1", i), gnt1, tv[i].g1);
            chk($sformatf("v%0d_stall0", i), stall0, tv[i].st);
            chk($sformatf("v%0d_mem_we", i), mem_we, tv[i].mwe);
            chk($sformatf("v%0d_mem_addr", i), mem_addr, tv[i].maddr);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_rvalid", i), {rvalid0, rvalid1}, {tv[i].rv0, tv[i].rv1});
            chk($sformatf("v%0d_rdata0", i), rdata0, tv[i].rd0);
            chk($sformatf("v%0d_rdata1", i), rdata1, tv[i].rd1);
            chk($sformatf("v%0d_err", i), {err0, err1}, {tv[i].e0, tv[i].e1});
        end

        // unlocked contention from reset
        begin
`ifdef DMEM_ARB_RR_EN
            logic [3:0] eg0 = 4'b0101;  // bit k = cycle k: 0,1,0,1
`else
            logic [3:0] eg0 = 4'b1111;
`endif
            do_reset();
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                drive(H, L, 16'd1, 16'd0, H, L, 16'd2, 16'd0, L);
                #1;
                chk($sformatf("cont%0d_gnt0", k), gnt0, eg0[k]);
                chk($sformatf("cont%0d_gnt1", k), gnt1, !eg0[k]);
                chk($sformatf("cont%0d_stall0", k), stall0, !eg0[k]);
                @(posedge clk);
                #1;
                chk($sformatf("cont%0d_rdata0", k), rdata0, eg0[k] ? 16'hA001 : 16'h0);
                chk($sformatf("cont%0d_rdata1", k), rdata1, eg0[k] ? 16'h0 : 16'hA002);
            end
        end

        // lock: lone locked port-1 grant, then port 0 joins; released after 3
        begin
            logic [3:0] eg1 = 4'b0111;
            logic [3:0] est = 4'b0110;
            logic [7:0] elc [4] = '{8'd1, 8'd2, 8'd3, 8'd0};
            do_reset();
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                drive(k > 0, L, 16'd1, 16'd0, H, L, 16'd2, 16'd0, H);
                #1;
                chk($sformatf("lock%0d_gnt1", k), gnt1, eg1[k]);
                chk($sformatf("lock%0d_gnt0", k), gnt0, !eg1[k]);
                chk($sformatf("lock%0d_stall0", k), stall0, est[k]);
                @(posedge clk);
                #1;
                chk($sformatf("lock%0d_lcnt", k), dut.lcnt, elc[k]);
            end
            chk("lock_hold_after", dut.lock_hold, 0);
            @(negedge clk);
            drive(L, L, 16'd0, 16'd0, L, L, 16'd0, 16'd0, L);
        end

        // async reset during a locked port-1 read burst
        do_reset();
        @(negedge clk);
        drive(L, L, 16'd0, 16'd0, H, L, 16'd2, 16'd0, H);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("burst_rvalid1_pre", rvalid1, 1);
        chk("burst_hold_pre", dut.lock_hold, 1);
        #1;
        rst = 1'b0;
        #1;
        chk("burst_rvalid1_rst", rvalid1, 0);
        chk("burst_rdata1_rst", rdata1, 0);
        @(negedge clk);
        drive(L, L, 16'd0, 16'd0, L, L, 16'd0, 16'd0, L);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("burst_rvalid1_post", rvalid1, 0);
        chk("burst_hold_post", dut.lock_hold, 0);
        chk("burst_lcnt_post", dut.lcnt, 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
